// File: rtl/sme_result_q.sv
// Result queue between the SME execute pipeline and host writeback.
// Circular buffer with zeroised free entries and a pending-write hazard check.

module sme_result_q_entry #(
    parameter int XLEN = 32
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            clr,
    input  logic            wr,
    input  logic [3:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            vld,
    output logic [3:0]      addr,
    output logic [XLEN-1:0] data
);
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            vld  <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (clr) begin
            vld  <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (wr) begin
            vld  <= 1'b1;
            addr <= wr_addr;
            data <= wr_data;
        end
    end
endmodule

module sme_result_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     flush,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [XLEN-1:0]          res_rd_wdata,
    input  logic [3:0]               res_rd_addr,
    output logic                     host_valid,
    input  logic                     host_ready,
    output logic [XLEN-1:0]          host_rd_wdata,
    output logic [3:0]               host_rd_addr,
    input  logic [3:0]               hz_addr,
    output logic                     hz_hit,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]                  rptr, wptr;
    logic [CW-1:0]                  count_q;
    logic [DEPTH-1:0]               e_vld;
    logic [DEPTH-1:0][3:0]          e_addr;
    logic [DEPTH-1:0][XLEN-1:0]     e_data;
    logic                           push, push_st, pop;

    assign res_ready  = (count_q != FULL);
    assign host_valid = (count_q != '0);
    assign push       = res_valid && res_ready;
    // writes to x0 complete the handshake but are never stored
    assign push_st    = push && (res_rd_addr != 4'd0);
    assign pop        = host_valid && host_ready;
    assign count      = count_q;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            sme_result_q_entry #(.XLEN(XLEN)) u_ent (
                .g_clk    (g_clk),
                .g_resetn (g_resetn),
                .clr      (flush || (pop && (rptr == AW'(i)))),
                .wr       (push_st && (wptr == AW'(i))),
                .wr_addr  (res_rd_addr),
                .wr_data  (res_rd_wdata),
                .vld      (e_vld[i]),
                .addr     (e_addr[i]),
                .data     (e_data[i])
            );
        end
    endgenerate

    // head slot is zero whenever the queue is empty, so no masking needed
    assign host_rd_wdata = e_data[rptr];
    assign host_rd_addr  = e_addr[rptr];

    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_vld[i] && (e_addr[i] == hz_addr)) hz_hit = 1'b1;
        end
        if (hz_addr == 4'd0) hz_hit = 1'b0;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rptr    <= '0;
            wptr    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rptr    <= '0;
            wptr    <= '0;
            count_q <= '0;
        end else begin
            if (push_st) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_st, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
